// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h00000013;
   localparam int          FETCH_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misaligned;
   } fetch_entry_t;

endpackage

// File: rtl/adder4.sv
// rtl/adder4.sv - constant +4 incrementer used for sequential pc computation
module adder4 (
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = a + 32'd4;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular buffer of pc/instruction pairs between fetch and decode
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_instr,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc_plus4,
   output logic                       out_misaligned,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem [DEPTH];
   fetch_entry_t   head_entry;
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count_q;
   logic           push;
   logic           pop;

   assign in_ready  = (count_q < CW'(DEPTH)) && !rst;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign count     = count_q;

   // Pointers are exactly log2(DEPTH) wide, so incrementing wraps DEPTH-1 to 0.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{pc: in_pc, instr: in_instr, misaligned: (in_pc[1:0] != 2'b00)};
      end
   end

   assign head_entry = mem[head];

   // Stale slot contents are masked to a NOP bubble whenever the queue is empty.
   always_comb begin
      out_pc         = 32'h0;
      out_instr      = NOP_INSTR;
      out_misaligned = 1'b0;
      if (out_valid) begin
         out_pc         = head_entry.pc;
         out_instr      = head_entry.instr;
         out_misaligned = head_entry.misaligned;
      end
   end

   adder4 pc_plus4_inc (
      .a (out_pc),
      .y (out_pc_plus4)
   );

endmodule
